mac_lane_array: RTL and testbench

MAC_LANE_ARRAY -- requirements
Module: mac_lane_array

---
 rtl/mac_lane_array.sv | 171 +++++++++++++++++
 tb/tb_mac_lane_array.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mac_lane_array.sv
// Multi-lane signed multiply-accumulate engine: LANES parallel MACs share one job
// length and one valid/ready operand stream, and produce a saturated result vector.
module mac_lane_array #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [CNT_W-1:0]          len_i,
  output logic                      busy_o,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*DATA_W-1:0]   in_act_i,
  input  logic [LANES*DATA_W-1:0]   in_wgt_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANES*OUT_W-1:0]    out_data_o,
  output logic [LANES-1:0]          out_sat_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, HOLD = 2'd3} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   len_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               flush_cnt_r;
  logic               prod_vld_r;
  logic               out_valid_r;
  logic               accept_s;
  logic               start_ok_s;
  logic               last_beat_s;
  logic               hs_s;
  logic               flush_done_s;

  // Returns {clipped_flag, value} for one accumulator.
  function automatic logic [OUT_W:0] clip(input logic signed [ACC_W-1:0] a);
    logic [OUT_W:0] r;
    if (a > SAT_MAX) begin
      r = {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (a < SAT_MIN) begin
      r = {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      r = {1'b0, a[OUT_W-1:0]};
    end
    return r;
  endfunction

  assign accept_s     = in_valid_i && (state_r == RUN);
  assign start_ok_s   = (state_r == IDLE) && start_i && (len_i != {CNT_W{1'b0}});
  assign cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign last_beat_s  = accept_s && (cnt_next_s == len_r);
  assign hs_s         = out_valid_r && out_ready_i;
  assign flush_done_s = (state_r == FLUSH) && flush_cnt_r;

  assign busy_o      = (state_r != IDLE);
  assign in_ready_o  = (state_r == RUN);
  assign out_valid_o = out_valid_r;

  // Next-state logic; clear wins over every other condition.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start_ok_s ? RUN : IDLE;
      RUN:     state_s = last_beat_s ? FLUSH : RUN;
      FLUSH:   state_s = flush_cnt_r ? HOLD : FLUSH;
      HOLD:    state_s = hs_s ? IDLE : HOLD;
      default: state_s = IDLE;
    endcase
    if (clear_i) begin
      state_s = IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // Control registers: state, job length, beat counter, flush timer, valid flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r     <= IDLE;
      len_r       <= {CNT_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      flush_cnt_r <= 1'b0;
      prod_vld_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (clear_i) begin
      state_r     <= IDLE;
      len_r       <= {CNT_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      flush_cnt_r <= 1'b0;
      prod_vld_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      prod_vld_r  <= accept_s;
      flush_cnt_r <= (state_r == FLUSH) ? ~flush_cnt_r : 1'b0;
      // Valid rises one cycle into HOLD, after the result registers have settled.
      out_valid_r <= (state_r == HOLD) && !hs_s;
      if (start_ok_s) begin
        len_r <= len_i;
        cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
        cnt_r <= cnt_next_s;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      logic signed [DATA_W-1:0]   act_s;
      logic signed [DATA_W-1:0]   wgt_s;
      logic signed [2*DATA_W-1:0] mul_s;
      logic signed [2*DATA_W-1:0] prod_r;
      logic signed [ACC_W-1:0]    acc_r;
      logic [OUT_W:0]             clip_s;
      logic [OUT_W-1:0]           out_lane_r;
      logic                       out_sat_r;

      assign act_s  = in_act_i[k*DATA_W +: DATA_W];
      assign wgt_s  = in_wgt_i[k*DATA_W +: DATA_W];
      assign mul_s  = (2*DATA_W)'(act_s) * (2*DATA_W)'(wgt_s);
      assign clip_s = clip(acc_r);

      // Two-stage MAC: product register, then wrapping accumulate.
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          prod_r <= {(2*DATA_W){1'b0}};
          acc_r  <= {ACC_W{1'b0}};
        end else if (clear_i || start_ok_s) begin
          prod_r <= {(2*DATA_W){1'b0}};
          acc_r  <= {ACC_W{1'b0}};
        end else begin
          if (accept_s) begin
            prod_r <= mul_s;
          end
          if (prod_vld_r) begin
            acc_r <= acc_r + ACC_W'(prod_r);
          end
        end
      end

      // Result register, loaded once at the end of the flush window.
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          out_lane_r <= {OUT_W{1'b0}};
          out_sat_r  <= 1'b0;
        end else if (clear_i) begin
          out_lane_r <= {OUT_W{1'b0}};
          out_sat_r  <= 1'b0;
        end else if (flush_done_s) begin
          out_lane_r <= clip_s[OUT_W-1:0];
          out_sat_r  <= clip_s[OUT_W];
        end
      end

      assign out_data_o[k*OUT_W +: OUT_W] = out_lane_r;
      assign out_sat_o[k]                 = out_sat_r;
    end
  endgenerate

endmodule

// File: tb/tb_mac_lane_array.sv
// Directed self-checking bench for mac_lane_array with default parameters.
module tb_mac_lane_array;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = 16'd0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_act = 32'd0;
  logic [31:0] in_wgt = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [3:0]  out_sat;

  int n_chk = 0;
  int n_fail = 0;

  mac_lane_array dut (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .start_i(start), .len_i(len),
    .busy_o(busy), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_act_i(in_act), .in_wgt_i(in_wgt), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_sat_o(out_sat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int k);
    return {16'h0000, out_data[k*16 +: 16]};
  endfunction

  task automatic ops(input logic [7:0] a0, input logic [7:0] w0, input logic [7:0] a1,
                     input logic [7:0] w1, input logic [7:0] a2, input logic [7:0] w2,
                     input logic [7:0] a3, input logic [7:0] w3);
    in_act = {a3, a2, a1, a0};
    in_wgt = {w3, w2, w1, w0};
  endtask

  task automatic begin_job(input logic [15:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_ready",  32'(in_ready), 32'd0);
    check("rst_valid",  32'(out_valid), 32'd0);
    check("rst_data",   out_data[31:0], 32'd0);
    check("rst_sat",    32'(out_sat), 32'd0);
    step();
    rstn = 1'b1;
    step();

    // Basic signed accumulation and latency
    begin_job(16'd3);
    check("t1_busy",  32'(busy), 32'd1);
    check("t1_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    ops(8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);   step();
    ops(8'hFC, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);  step();
    ops(8'd7, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);  step();  // edge E
    in_valid = 1'b0;
    check("t1_ready_flush", 32'(in_ready), 32'd0);
    check("t1_valid_e0", 32'(out_valid), 32'd0);
    step();
    check("t1_valid_e1", 32'(out_valid), 32'd0);
    step();
    check("t1_valid_e2", 32'(out_valid), 32'd0);
    step();
    check("t1_valid_e3", 32'(out_valid), 32'd1);
    check("t1_lane0", lane(0), 32'h0000FFEB);
    check("t1_lane1", lane(1), 32'd0);
    check("t1_sat",   32'(out_sat), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_valid_done", 32'(out_valid), 32'd0);
    check("t1_busy_done",  32'(busy), 32'd0);

    // Saturation in both directions plus unclipped lanes
    begin_job(16'd4);
    in_valid = 1'b1;
    ops(8'd127, 8'd127, 8'h80, 8'd127, 8'hFD, 8'd100, 8'd10, 8'd10);
    repeat (4) step();
    in_valid = 1'b0;
    repeat (3) step();
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_lane0", lane(0), 32'h00007FFF);
    check("t2_lane1", lane(1), 32'h00008000);
    check("t2_lane2", lane(2), 32'h0000FB50);
    check("t2_lane3", lane(3), 32'h00000190);
    check("t2_sat",   32'(out_sat), 32'h3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Bubbles ignored and result held under backpressure
    begin_job(16'd2);
    in_valid = 1'b1;
    ops(8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);     step();
    in_valid = 1'b0;
    ops(8'd100, 8'd100, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0); step();
    check("t3_ready_bubble", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b1;
    ops(8'hFE, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("t3_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_lane0", lane(0), 32'h00000016);
      check("t3_hold_lane1", lane(1), 32'd0);
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_idle", 32'(busy), 32'd0);

    // Clear mid-job, then a fresh single-beat job
    begin_job(16'd4);
    in_valid = 1'b1;
    ops(8'd50, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);   step();
    in_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t4_busy_clr",  32'(busy), 32'd0);
    check("t4_ready_clr", 32'(in_ready), 32'd0);
    begin_job(16'd1);
    in_valid = 1'b1;
    ops(8'd3, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);     step();
    in_valid = 1'b0;
    repeat (3) step();
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_lane0", lane(0), 32'h00000009);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Zero-length start ignored; start during RUN does not relatch length
    begin_job(16'd0);
    check("t5_len0_busy", 32'(busy), 32'd0);
    begin_job(16'd2);
    in_valid = 1'b1;
    ops(8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);     step();
    start = 1'b1;
    len   = 16'd5;
    ops(8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);     step();
    start = 1'b0;
    in_valid = 1'b0;
    check("t5_flush_busy",  32'(busy), 32'd1);
    check("t5_flush_ready", 32'(in_ready), 32'd0);
    repeat (3) step();
    check("t5_valid", 32'(out_valid), 32'd1);
    check("t5_lane0", lane(0), 32'h00000005);

    // Asynchronous reset while holding a result
    rstn = 1'b0;
    #2;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data",  out_data[31:0], 32'd0);
    check("t6_busy",  32'(busy), 32'd0);
    step();
    rstn = 1'b1;
    step();
    check("t6_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
